// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the sequential floating-point units.
// Holds the field widths, exponent limits, canonical special encodings, the divider
// state type and iteration count, and small packing helpers.
package fp_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned SIG_W  = MANT_W + 1;  // mantissa with hidden bit

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    // Divider datapath sizing: 24 quotient bits plus guard plus one bit of headroom
    // for the case where the mantissa ratio is below one.
    localparam int unsigned DIV_ITERS = 26;
    localparam int unsigned QUO_W     = DIV_ITERS;
    localparam int unsigned REM_W     = SIG_W + 1;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StDivide,
        StRound,
        StDone
    } div_state_e;

    function automatic logic [FP_W-1:0] fp_inf(input logic sign);
        return {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    endfunction

    function automatic logic [FP_W-1:0] fp_zero(input logic sign);
        return {sign, {(FP_W-1){1'b0}}};
    endfunction

    function automatic logic [FP_W-1:0] fp_pack(input logic              sign,
                                                 input logic [EXP_W-1:0]  exp,
                                                 input logic [MANT_W-1:0] mant);
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Request/response bundle of the sequential divider.
//   start        : request, taken only while ready is high
//   a, b         : dividend and divisor, captured with an accepted start
//   ready        : divider is idle
//   done         : one-cycle completion pulse
//   result       : quotient, held until the next done
//   div_by_zero  : finite nonzero divided by zero, held with result
// master = requester, slave = divider.
interface fp_div_seq_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    modport master (
        output start,
        output a,
        output b,
        input  ready,
        input  done,
        input  result,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ready,
        output done,
        output result,
        output div_by_zero
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational binary32 operand unpacker.
//   op       : binary32 operand
//   sign     : sign bit
//   exp      : biased exponent field
//   mant     : mantissa with the hidden bit set
//   is_zero  : exponent field zero (subnormals count as zero)
//   is_inf   : infinity
//   is_nan   : any NaN
module fp_classify
    import fp_pkg::*;
(
    input  logic [FP_W-1:0]  op,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [SIG_W-1:0] mant,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan
);

    logic [MANT_W-1:0] frac;
    logic              exp_all_ones;

    assign sign         = op[FP_W-1];
    assign exp          = op[FP_W-2:MANT_W];
    assign frac         = op[MANT_W-1:0];
    assign exp_all_ones = (exp == {EXP_W{1'b1}});

    assign mant    = {1'b1, frac};
    assign is_zero = (exp == '0);
    assign is_inf  = exp_all_ones && (frac == '0);
    assign is_nan  = exp_all_ones && (frac != '0);

endmodule

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: result = a / b.
// Restoring radix-2 mantissa division, one quotient bit per cycle, round to nearest even,
// flush-to-zero on underflow, full NaN/inf/zero handling.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, aborts any division in flight
//   bus   : fp_div_seq_if slave (start/a/b in, ready/done/result/div_by_zero out)
// Latency from the accepting edge: done after edge 28 (normal) or edge 1 (special case).
module fp_div_seq
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fp_div_seq_if.slave  bus
);

    div_state_e state_q, state_d;

    logic [FP_W-1:0]   a_q, a_d;
    logic [FP_W-1:0]   b_q, b_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [SIG_W-1:0]  div_q, div_d;
    logic [QUO_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic signed [9:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [FP_W-1:0]   result_q, result_d;
    logic              dbz_q, dbz_d;

    // Operand unpacking
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [SIG_W-1:0] ma, mb;
    logic             a_zero, a_inf, a_nan;
    logic             b_zero, b_inf, b_nan;

    fp_classify u_class_a (
        .op      (a_q),
        .sign    (sa),
        .exp     (ea),
        .mant    (ma),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan)
    );

    fp_classify u_class_b (
        .op      (b_q),
        .sign    (sb),
        .exp     (eb),
        .mant    (mb),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan)
    );

    // Restoring step
    logic [REM_W-1:0] div_ext;
    logic [REM_W-1:0] rem_diff;
    logic             rem_ge;

    assign div_ext  = {1'b0, div_q};
    assign rem_ge   = (rem_q >= div_ext);
    assign rem_diff = rem_q - div_ext;

    // Normalisation and rounding of the finished quotient
    logic [MANT_W-1:0] rnd_mant;
    logic              rnd_guard;
    logic              rnd_sticky;
    logic              rnd_up;
    logic [MANT_W:0]   rnd_mant_inc;
    logic signed [9:0] rnd_exp_norm;
    logic signed [9:0] rnd_exp;
    logic [FP_W-1:0]   rnd_result;

    always_comb begin
        rnd_mant     = '0;
        rnd_guard    = 1'b0;
        rnd_sticky   = 1'b0;
        rnd_exp_norm = exp_q;
        // q[25] is the integer bit of the mantissa ratio; when clear the ratio is in
        // (0.5, 1) and the leading one sits one position lower.
        if (quo_q[QUO_W-1]) begin
            rnd_mant   = quo_q[QUO_W-2:2];
            rnd_guard  = quo_q[1];
            rnd_sticky = quo_q[0] | (rem_q != '0);
        end else begin
            rnd_mant     = quo_q[QUO_W-3:1];
            rnd_guard    = quo_q[0];
            rnd_sticky   = (rem_q != '0);
            rnd_exp_norm = exp_q - 10'sd1;
        end

        rnd_up       = rnd_guard & (rnd_sticky | rnd_mant[0]);
        rnd_mant_inc = {1'b0, rnd_mant} + {{MANT_W{1'b0}}, rnd_up};
        // Carry out leaves the fraction at zero, so only the exponent needs bumping.
        rnd_exp      = rnd_mant_inc[MANT_W] ? rnd_exp_norm + 10'sd1 : rnd_exp_norm;

        if (rnd_exp >= $signed(10'(EXP_MAX))) begin
            rnd_result = fp_inf(sign_q);
        end else if (rnd_exp <= 10'sd0) begin
            rnd_result = fp_zero(sign_q);
        end else begin
            rnd_result = fp_pack(sign_q, rnd_exp[EXP_W-1:0], rnd_mant_inc[MANT_W-1:0]);
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = StPrep;
                end
            end

            StPrep: begin
                sign_d = sa ^ sb;
                dbz_d  = 1'b0;
                if (a_nan || b_nan) begin
                    result_d = QNAN;
                    state_d  = StDone;
                end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
                    result_d = QNAN;
                    state_d  = StDone;
                end else if (a_inf) begin
                    result_d = fp_inf(sa ^ sb);
                    state_d  = StDone;
                end else if (b_inf || a_zero) begin
                    result_d = fp_zero(sa ^ sb);
                    state_d  = StDone;
                end else if (b_zero) begin
                    result_d = fp_inf(sa ^ sb);
                    dbz_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb})
                              + $signed(10'(EXP_BIAS));
                    rem_d   = {1'b0, ma};
                    div_d   = mb;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = StDivide;
                end
            end

            StDivide: begin
                if (rem_ge) begin
                    rem_d = rem_diff << 1;
                    quo_d = {quo_q[QUO_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_q << 1;
                    quo_d = {quo_q[QUO_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                    state_d = StRound;
                end
            end

            StRound: begin
                result_d = rnd_result;
                dbz_d    = 1'b0;
                state_d  = StDone;
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.ready       = (state_q == StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases plus randomized operands compared
// against an exact integer-arithmetic model of IEEE division with RNE and flush-to-zero.
module tb_fp_div_seq;

    typedef struct packed {
        logic [31:0] res;
        logic        dbz;
        logic        special;
    } ref_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_div_seq_if bus ();

    fp_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Exact model: integer quotient of the significands with the true remainder.
    function automatic ref_t ref_div(input logic [31:0] a, input logic [31:0] b);
        ref_t              r;
        logic              s;
        int                ea, eb, e;
        logic [22:0]       fa, fb;
        bit                a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        longint unsigned   ma, mb, num, q, rm;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        fa     = a[22:0];
        fb     = b[22:0];
        a_nan  = (ea == 255) && (fa != 0);
        a_inf  = (ea == 255) && (fa == 0);
        a_zero = (ea == 0);
        b_nan  = (eb == 255) && (fb != 0);
        b_inf  = (eb == 255) && (fb == 0);
        b_zero = (eb == 0);
        r.special = 1'b1;
        r.dbz     = 1'b0;
        r.res     = 32'h0;
        if (a_nan || b_nan)                            r.res = 32'h7FC0_0000;
        else if ((a_inf && b_inf) || (a_zero && b_zero)) r.res = 32'h7FC0_0000;
        else if (a_inf)                                r.res = {s, 31'h7F80_0000};
        else if (b_inf || a_zero)                      r.res = {s, 31'h0};
        else if (b_zero) begin
            r.res = {s, 31'h7F80_0000};
            r.dbz = 1'b1;
        end else begin
            r.special = 1'b0;
            ma = 64'h80_0000 | 64'(fa);
            mb = 64'h80_0000 | 64'(fb);
            e  = ea - eb + 127;
            if (ma >= mb) num = ma << 23;
            else begin
                num = ma << 24;
                e   = e - 1;
            end
            q  = num / mb;
            rm = num % mb;
            if ((2 * rm > mb) || ((2 * rm == mb) && (q % 2 == 1))) q = q + 1;
            if (q == 64'h100_0000) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255)    r.res = {s, 31'h7F80_0000};
            else if (e <= 0) r.res = {s, 31'h0};
            else             r.res = {s, 8'(e), 23'(q)};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned sel;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        sel = $urandom_range(0, 19);
        s   = 1'($urandom_range(0, 1));
        f   = 23'($urandom);
        e   = 8'($urandom_range(90, 164));
        case (sel)
            0: begin e = 8'd0;   f = 23'd0; end
            1: begin e = 8'd255; f = 23'd0; end
            2: begin e = 8'd255; f = f | 23'd1; end
            3: e = 8'd0;
            4: e = ($urandom_range(0, 1) == 1) ? 8'd1 : 8'd254;
            5: f = 23'd0;
            6: e = 8'($urandom_range(1, 254));
            default: ;
        endcase
        return {s, e, f};
    endfunction

    // Issue one division and check latency, result, flag, pulse width and hold.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit busy_pulses,
                          input bit start_on_done, input string tag);
        ref_t        r;
        int          n;
        int          lat_exp;
        r = ref_div(a, b);
        lat_exp = r.special ? 1 : 28;
        for (int i = 0; i < 8; i++) begin
            if (bus.ready === 1'b1) break;
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_ready_wait"}, {31'b0, bus.ready}, 32'd1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) break;
            if (busy_pulses) begin
                bus.start = (n % 3 == 0);
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
        end
        bus.start = start_on_done;
        bus.a     = 32'h3F80_0000;
        bus.b     = 32'h4000_0000;
        check_eq({tag, "_latency"}, 32'(n), 32'(lat_exp));
        check_eq({tag, "_result"}, bus.result, r.res);
        check_eq({tag, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, r.dbz});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
        check_eq({tag, "_ready_after"}, {31'b0, bus.ready}, 32'd1);
        check_eq({tag, "_hold"}, bus.result, r.res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'b0, bus.ready}, 32'd1);
        check_eq("rst_done", {31'b0, bus.done}, 32'd0);
        check_eq("rst_result", bus.result, 32'h0);
        check_eq("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(32'h4140_0000, 32'h4080_0000, 1'b0, 1'b0, "12div4");
        check_eq("12div4_val", bus.result, 32'h4040_0000);
        run_op(32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b1, "1div3");
        check_eq("1div3_val", bus.result, 32'h3EAA_AAAB);
        run_op(32'hC0C0_0000, 32'h4000_0000, 1'b0, 1'b0, "neg6div2");
        check_eq("neg6div2_val", bus.result, 32'hC040_0000);
        run_op(32'h4080_0000, 32'h0000_0000, 1'b0, 1'b0, "4div0");
        check_eq("4div0_val", bus.result, 32'h7F80_0000);
        check_eq("4div0_flag", {31'b0, bus.div_by_zero}, 32'd1);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "0div0");
        check_eq("0div0_val", bus.result, 32'h7FC0_0000);
        check_eq("0div0_flag_clr", {31'b0, bus.div_by_zero}, 32'd0);
        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0, "infdivinf");
        check_eq("infdivinf_val", bus.result, 32'h7FC0_0000);
        run_op(32'h7F00_0000, 32'h3E80_0000, 1'b1, 1'b0, "overflow");
        check_eq("overflow_val", bus.result, 32'h7F80_0000);
        run_op(32'h0080_0000, 32'h4B00_0000, 1'b0, 1'b1, "underflow");
        check_eq("underflow_val", bus.result, 32'h0000_0000);

        // Reset at edge 10 of a division aborts it with no done
        run_op(32'h4080_0000, 32'h4040_0000, 1'b0, 1'b0, "pre_abort");
        dc0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h4140_0000;
        bus.b     = 32'h4080_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_result", bus.result, 32'h0);
        check_eq("abort_ready", {31'b0, bus.ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h4040_0000, 32'h4040_0000, 1'b1, 1'b0, "after_abort");
        check_eq("after_abort_val", bus.result, 32'h3F80_0000);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_done_count", 32'(done_cnt - dc0), 32'd1);

        // Randomized operands
        for (int i = 0; i < 150; i++) begin
            run_op(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential IEEE-754 binary32 divider computing `a / b` with a restoring radix-2 mantissa loop, round-to-nearest-even, and full special-value handling. It is the inverse-operation companion to the combinational `fp_mul` in the convolution datapath. It is used for normalisation and scaling stages where a multi-cycle latency is acceptable in exchange for small area. Operation uses a start/ready/done handshake; one division is in flight at a time.

## Interface
- No parameters; the format is fixed at binary32 (1/8/23).
- `clk  in  1  ` rising-edge clock
- `rst  in  1  ` synchronous, active-high reset
- `start  in  1  ` request; sampled only while `ready`=1
- `a  in  32  ` dividend; captured on the edge that accepts `start`
- `b  in  32  ` divisor; captured with `a`
- `ready  out  1  ` high only in IDLE
- `done  out  1  ` one-cycle pulse; `result` is valid from this cycle onward
- `result  out  32  ` quotient; holds until the next `done`
- `div_by_zero  out  1  ` set with `done` when a finite nonzero value is divided by zero; holds with `result`

## Operation
- States: IDLE → PREP → DIVIDE → ROUND → DONE → IDLE. PREP goes directly to DONE for special cases.
- IDLE: `ready`=1. `start` registers `a`/`b` and moves to PREP. `start` outside IDLE is ignored.
- PREP:
  - Unpack the operands. Subnormal operands (exp=0) are treated as ±0.
  - Sign = sa^sb.
  - Special cases, first match wins:
    - either operand NaN → 7FC00000
    - inf/inf or 0/0 → 7FC00000
    - inf/x → ±inf
    - x/inf → ±0
    - 0/x → ±0
    - x/0 → ±inf with `div_by_zero`=1
  - Otherwise: exponent = ea − eb + 127 (10-bit signed); remainder = {1,ma}; divisor = {1,mb}; clear the 26-bit quotient.
- DIVIDE: 26 iterations, one per cycle.
  - If rem ≥ div: q bit = 1 and rem −= div. Otherwise q bit = 0.
  - Then rem <<= 1. Quotient bits are shifted in MSB-first.
- ROUND:
  - If q[25]=1: mant = q[24:2], guard = q[1], sticky = q[0] | (rem≠0).
  - Else: mant = q[23:1], guard = q[0], sticky = (rem≠0), and exponent −= 1.
  - RNE: increment when guard & (sticky | mant[0]). A mantissa carry-out increments the exponent.
  - exp ≥ 255 → ±inf. exp ≤ 0 → ±0 (flush-to-zero, no subnormal output).
- DONE: `done`=1 for one cycle; update `result`/`div_by_zero`; go to IDLE.
- `div_by_zero` is cleared on every `done` that is not a divide-by-zero.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=32'h0, `div_by_zero`=0.
- Reset mid-operation aborts the division without producing `done`. `result` returns to 0.
- Call the edge that samples `start` edge 0.
- Normal path: PREP at edge 1, DIVIDE on edges 2–27, ROUND at edge 28. `done` is high in the cycle after edge 28.
- Special path: `done` is high in the cycle after edge 1.
- `ready` returns high in the cycle after `done`. Back-to-back throughput is therefore 30 cycles (normal) or 3 cycles (special).
- `start` asserted in the same cycle as `done` is not accepted.
- `result` and `div_by_zero` are registered and change only on the edge that raises `done`, or on reset.

## Structure
- Shared package `fp_pkg`:
  - field widths, EXP_BIAS=127, EXP_MAX=255
  - QNAN=32'h7FC00000
  - the state enum and the iteration count (26)
  - reused later by fp_add/fp_sqrt.
- One combinational sub-module, `fp_classify`: per-operand is_zero / is_inf / is_nan, sign, exp and mantissa with the hidden bit. It is instantiated twice, in PREP.
- The main FSM, remainder/quotient registers, and rounding logic live in `fp_div_seq`.

## Test plan
- 41400000 / 40800000 (12/4) → 40400000; `done` in the cycle after edge 28; `div_by_zero`=0.
- 3F800000 / 40400000 (1/3) → 3EAAAAAB (checks the RNE round-up).
- C0C00000 / 40000000 → C0400000. Then 40800000 / 00000000 → 7F800000 with `div_by_zero`=1 and `done` after edge 1.
- Invalid and overflow cases:
  - 00000000 / 00000000 → 7FC00000
  - 7F800000 / 7F800000 → 7FC00000
  - 7F000000 / 3E800000 → 7F800000 (overflow)
  - 00800000 / 4B000000 → 00000000 (underflow)
- Assert `rst` at edge 10 of a division, then issue 40400000 / 40400000 → only one `done`, with 3F800000. `start` pulses while busy are ignored.
